// File: rtl/password_entry_controller.sv
// Password entry controller for a BCD keypad.
//
// Digits are collected into entry_buf, with the newest digit in the LSB nibble.
// On enter, the entry is compared with the stored password during a one-cycle CHECK state.
// - A match opens the lock.
// - Each mismatch pulses fail.
// - MAX_FAIL consecutive mismatches force a LOCK_CYCLES-long lockout.
//
// While unlocked, a full-length entry followed by enter replaces the stored password.
// A clear with an empty entry relocks.
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   reset      - asynchronous active-high reset
//   key_valid  - one-cycle pulse, key_digit holds a digit
//   key_digit  - BCD digit 0..9 (codes above 9 are ignored)
//   key_enter  - one-cycle pulse, submit the entry
//   key_clear  - one-cycle pulse, discard the entry or relock when the entry is empty
//   count      - number of digits currently entered (0..DIGITS)
//   unlocked   - high while unlocked
//   fail       - one-cycle pulse after a mismatch
//   locked_out - high during lockout
module password_entry_controller #(
    parameter int unsigned         DIGITS      = 6,
    parameter logic [4*DIGITS-1:0] INIT_PW     = 24'h123456,
    parameter int unsigned         MAX_FAIL    = 3,
    parameter int unsigned         LOCK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [3:0]                    key_digit,
    input  logic                          key_enter,
    input  logic                          key_clear,
    output logic [$clog2(DIGITS+1)-1:0]   count,
    output logic                          unlocked,
    output logic                          fail,
    output logic                          locked_out
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);
    localparam int unsigned TW = $clog2(LOCK_CYCLES + 1);

    localparam logic [CW-1:0] CntFull   = CW'(DIGITS);
    localparam logic [FW-1:0] FailLast  = FW'(MAX_FAIL - 1);
    localparam logic [TW-1:0] TimerLast = TW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {StEntry, StCheck, StUnlocked, StLockout} state_e;

    state_e        state;
    logic [BW-1:0] entry_buf;
    logic [BW-1:0] pw_reg;
    logic [FW-1:0] fail_cnt;
    logic [TW-1:0] lock_timer;
    logic          digit_ok;

    // A digit is accepted only if it is valid BCD and the entry is not yet full.
    assign digit_ok = key_valid && (key_digit <= 4'd9) && (count != CntFull);

    assign unlocked   = (state == StUnlocked);
    assign locked_out = (state == StLockout);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StEntry;
            count      <= '0;
            entry_buf  <= '0;
            pw_reg     <= INIT_PW;
            fail_cnt   <= '0;
            lock_timer <= '0;
            fail       <= 1'b0;
        end else begin
            fail <= 1'b0;
            unique case (state)
                StEntry: begin
                    if (key_clear) begin
                        count     <= '0;
                        entry_buf <= '0;
                    end else if (key_enter) begin
                        state <= StCheck;
                    end else if (digit_ok) begin
                        entry_buf <= {entry_buf[BW-5:0], key_digit};
                        count     <= count + 1'b1;
                    end
                end

                // Keys are ignored here.
                // The entry is always discarded on the way out.
                StCheck: begin
                    count     <= '0;
                    entry_buf <= '0;
                    if (count == CntFull && entry_buf == pw_reg) begin
                        state    <= StUnlocked;
                        fail_cnt <= '0;
                    end else begin
                        fail     <= 1'b1;
                        fail_cnt <= fail_cnt + 1'b1;
                        if (fail_cnt == FailLast) begin
                            state      <= StLockout;
                            lock_timer <= '0;
                        end else begin
                            state <= StEntry;
                        end
                    end
                end

                StUnlocked: begin
                    if (key_clear) begin
                        if (count != '0) begin
                            count     <= '0;
                            entry_buf <= '0;
                        end else begin
                            state <= StEntry;
                        end
                    end else if (key_enter) begin
                        // Only a full-length entry may become the new password.
                        if (count == CntFull) begin
                            pw_reg <= entry_buf;
                        end
                        count     <= '0;
                        entry_buf <= '0;
                    end else if (digit_ok) begin
                        entry_buf <= {entry_buf[BW-5:0], key_digit};
                        count     <= count + 1'b1;
                    end
                end

                StLockout: begin
                    count <= '0;
                    if (lock_timer == TimerLast) begin
                        state      <= StEntry;
                        fail_cnt   <= '0;
                        lock_timer <= '0;
                    end else begin
                        lock_timer <= lock_timer + 1'b1;
                    end
                end

                default: state <= StEntry;
            endcase
        end
    end

endmodule

// File: tb/tb_password_entry_controller.sv
// Bench for password_entry_controller.
//
// A behavioural model tracks the following items:
// - the entered digits as a queue
// - the password as a digit list
// - a pending-check flag
// - an unlocked flag
// - the consecutive-failure count
// - the remaining lockout cycles
//
// The DUT outputs are compared with this model on every falling edge.
// Directed sequences also pin specific values by hand.
module tb_password_entry_controller;

    localparam int DIGITS      = 6;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic [2:0] count;
    logic       unlocked;
    logic       fail;
    logic       locked_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    password_entry_controller #(
        .DIGITS      (DIGITS),
        .INIT_PW     (24'h123456),
        .MAX_FAIL    (MAX_FAIL),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_enter  (key_enter),
        .key_clear  (key_clear),
        .count      (count),
        .unlocked   (unlocked),
        .fail       (fail),
        .locked_out (locked_out)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    int m_entered[$];
    int m_pw[$];
    bit m_unl;
    bit m_check;
    bit m_fail;
    int m_fails;
    int m_lock_left;

    function automatic bit same_code();
        if (m_entered.size() != DIGITS || m_pw.size() != DIGITS) return 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (m_entered[i] != m_pw[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_entered.delete();
        m_pw        = {1, 2, 3, 4, 5, 6};
        m_unl       = 1'b0;
        m_check     = 1'b0;
        m_fail      = 1'b0;
        m_fails     = 0;
        m_lock_left = 0;
    endtask

    task automatic model_step();
        m_fail = 1'b0;
        if (m_check) begin
            m_check = 1'b0;
            if (same_code()) begin
                m_unl   = 1'b1;
                m_fails = 0;
            end else begin
                m_fail = 1'b1;
                m_fails++;
                if (m_fails == MAX_FAIL) m_lock_left = LOCK_CYCLES;
            end
            m_entered.delete();
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (key_clear) begin
            if (m_unl && m_entered.size() == 0) m_unl = 1'b0;
            else m_entered.delete();
        end else if (key_enter) begin
            if (m_unl) begin
                if (m_entered.size() == DIGITS) m_pw = m_entered;
                m_entered.delete();
            end else begin
                m_check = 1'b1;
            end
        end else if (key_valid && key_digit <= 4'd9 && m_entered.size() < DIGITS) begin
            m_entered.push_back(int'(key_digit));
        end
    endtask

    initial model_reset();

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_count", int'(count), m_entered.size());
            chk("model_unlocked", int'(unlocked), int'(m_unl));
            chk("model_fail", int'(fail), int'(m_fail));
            chk("model_locked_out", int'(locked_out), int'(m_lock_left > 0));
        end
    end

    // Stimulus helpers: each call starts 1 time unit after a rising edge and ends at the same point
    // after the next edge.
    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic enter_k();
        key_enter = 1'b1;
        @(posedge clk);
        #1;
        key_enter = 1'b0;
    endtask

    task automatic clear_k();
        key_clear = 1'b1;
        @(posedge clk);
        #1;
        key_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic type_code(input logic [23:0] v);
        for (int i = 0; i < 6; i++) press(v[23-4*i -: 4]);
    endtask

    initial begin
        int n;

        // Reset is asserted before any clock edge, so these checks also cover its asynchronous action.
        #1 reset = 1'b1;
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_unlocked", int'(unlocked), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_locked_out", int'(locked_out), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Digit counting, saturation, priority and invalid BCD
        for (int i = 0; i < 6; i++) begin
            press(4'(i + 1));
            chk("count_step", int'(count), i + 1);
        end
        press(4'd7);
        chk("sat_count", int'(count), 6);
        key_clear = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd3;
        @(posedge clk);
        #1;
        key_clear = 1'b0;
        key_valid = 1'b0;
        chk("clear_over_valid", int'(count), 0);
        press(4'hA);
        chk("bad_bcd_ignored", int'(count), 0);
        press(4'd5);
        chk("one_digit", int'(count), 1);
        clear_k();
        chk("clear_entry", int'(count), 0);

        // Correct entry: unlocked is high one edge after the CHECK edge
        type_code(24'h123456);
        enter_k();
        chk("check_not_yet", int'(unlocked), 0);
        idle(1);
        chk("unlock_ok", int'(unlocked), 1);
        chk("unlock_count0", int'(count), 0);
        chk("unlock_nofail", int'(fail), 0);
        clear_k();
        chk("relock", int'(unlocked), 0);

        // Three wrong entries lead to lockout
        for (int k = 0; k < 3; k++) begin
            type_code(24'h123457);
            enter_k();
            idle(1);
            chk("wrong_fail", int'(fail), 1);
            chk("wrong_lock", int'(locked_out), int'(k == 2));
        end

        // Keys are ignored during lockout.
        // Lockout must last exactly LOCK_CYCLES edges.
        press(4'd5);
        chk("lock_key_ignored", int'(count), 0);
        n = 1;
        while (locked_out && n < LOCK_CYCLES + 20) begin
            idle(1);
            n++;
        end
        chk("lock_len", n, LOCK_CYCLES);
        type_code(24'h123456);
        enter_k();
        idle(1);
        chk("unlock_after_lock", int'(unlocked), 1);

        // Change the password to 987654, then relock
        type_code(24'h987654);
        enter_k();
        chk("pwchg_count0", int'(count), 0);
        chk("pwchg_still_unl", int'(unlocked), 1);
        clear_k();
        chk("pwchg_relock", int'(unlocked), 0);
        type_code(24'h987654);
        enter_k();
        idle(1);
        chk("new_pw_unlocks", int'(unlocked), 1);
        clear_k();
        type_code(24'h123456);
        enter_k();
        idle(1);
        chk("old_pw_fails", int'(fail), 1);
        chk("old_pw_locked", int'(unlocked), 0);

        // A key press during the CHECK cycle is dropped
        type_code(24'h111111);
        enter_k();
        press(4'd2);
        chk("check_fail2", int'(fail), 1);
        chk("check_key_ignored", int'(count), 0);
        press(4'd3);
        enter_k();
        idle(1);
        chk("lock_again", int'(locked_out), 1);

        // Asynchronous reset in the middle of lockout, between clock edges
        idle(10);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_lock", int'(locked_out), 0);
        chk("async_rst_count", int'(count), 0);
        #8 reset = 1'b0;
        @(posedge clk);
        #1;
        type_code(24'h123456);
        enter_k();
        idle(1);
        chk("init_pw_restored", int'(unlocked), 1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
